// File: rtl/mem_arb_pkg.sv
// Shared types for mem_port_arbiter: FSM states, owner encoding and the latched memory command.
// AW/DW are fixed here so the command struct and the bus interface agree on widths.
package mem_arb_pkg;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP} arb_state_t;

  typedef enum logic {OWN_IF, OWN_D} owner_t;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [BW-1:0] be;
  } mem_cmd_t;

  // Stores return an all-zero data word alongside their ack.
  function automatic logic [DW-1:0] resp_data(input logic we, input logic [DW-1:0] rdata);
    return we ? '0 : rdata;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester (IF/D) and memory-side handshake bundle; master = pipeline/memory environment, slave = arbiter.
interface mem_port_arbiter_if;
  import mem_arb_pkg::*;

  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [BW-1:0] d_be;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;

  logic          err;

  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [BW-1:0] mem_be;
  logic          mem_ready;
  logic          mem_rvalid;
  logic [DW-1:0] mem_rdata;

  modport master (
    output if_req, if_addr,
    output d_req, d_we, d_addr, d_wdata, d_be,
    output mem_ready, mem_rvalid, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata,
    input  d_gnt, d_rvalid, d_rdata, err,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );

  modport slave (
    input  if_req, if_addr,
    input  d_req, d_we, d_addr, d_wdata, d_be,
    input  mem_ready, mem_rvalid, mem_rdata,
    output if_gnt, if_rvalid, if_rdata,
    output d_gnt, d_rvalid, d_rdata, err,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );

endinterface

// File: rtl/mem_arb_pick.sv
// Winner select between fetch and data requests. MEM_ARB_RR_EN: round-robin with a pointer that
// flips to the loser on each pick; otherwise fixed priority with D always ahead of IF.
module mem_arb_pick
  import mem_arb_pkg::*;
(
`ifdef MEM_ARB_RR_EN
  input  logic   i_clk,
  input  logic   i_reset,
  input  logic   i_take,
`endif
  input  logic   i_if_req,
  input  logic   i_d_req,
  output logic   o_any,
  output owner_t o_winner
);

  assign o_any = i_if_req | i_d_req;

`ifdef MEM_ARB_RR_EN
  owner_t r_rr_ptr;

  always_comb begin
    o_winner = OWN_IF;
    if (i_if_req && i_d_req) begin
      o_winner = r_rr_ptr;
    end else if (i_d_req) begin
      o_winner = OWN_D;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rr_ptr <= OWN_IF;
    end else if (i_take) begin
      r_rr_ptr <= (o_winner == OWN_D) ? OWN_IF : OWN_D;
    end
  end
`else
  assign o_winner = i_d_req ? OWN_D : OWN_IF;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises IF/D accesses onto one memory port, one transaction outstanding; req->rvalid min 3 cycles,
// command held while mem_ready=0, watchdog ends a hung access with rvalid+err. Build option: MEM_ARB_RR_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MAX_WAIT = 15
) (
  input logic               i_clk,
  input logic               i_reset,
  mem_port_arbiter_if.slave bus
);

  localparam int WDW = $clog2(MAX_WAIT + 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(MAX_WAIT - 1);

  arb_state_t    r_state;
  owner_t        r_owner;
  mem_cmd_t      r_cmd;
  logic          r_mem_req;
  logic [WDW-1:0] r_wd;
  logic          r_if_rvalid;
  logic          r_d_rvalid;
  logic          r_err;
  logic [DW-1:0] r_if_rdata;
  logic [DW-1:0] r_d_rdata;

  logic          w_any;
  logic          w_take;
  logic          w_accept;
  owner_t        w_winner;
  logic [DW-1:0] w_resp;

  assign w_take   = (r_state == IDLE) && w_any;
  // Gated by reset so an acceptance in the reset cycle never reaches a requester.
  assign w_accept = (r_state == ISSUE) && bus.mem_ready && !i_reset;
  assign w_resp   = resp_data(r_cmd.we, bus.mem_rdata);

  mem_arb_pick u_pick (
`ifdef MEM_ARB_RR_EN
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_take   (w_take),
`endif
    .i_if_req (bus.if_req),
    .i_d_req  (bus.d_req),
    .o_any    (w_any),
    .o_winner (w_winner)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= IDLE;
      r_owner     <= OWN_D;
      r_cmd       <= '0;
      r_mem_req   <= 1'b0;
      r_wd        <= '0;
      r_if_rvalid <= 1'b0;
      r_d_rvalid  <= 1'b0;
      r_err       <= 1'b0;
      r_if_rdata  <= '0;
      r_d_rdata   <= '0;
    end else begin
      r_if_rvalid <= 1'b0;
      r_d_rvalid  <= 1'b0;
      r_err       <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_take) begin
            r_owner   <= w_winner;
            r_mem_req <= 1'b1;
            r_state   <= ISSUE;
            if (w_winner == OWN_D) begin
              r_cmd <= '{we: bus.d_we, addr: bus.d_addr, wdata: bus.d_wdata, be: bus.d_be};
            end else begin
              r_cmd <= '{we: 1'b0, addr: bus.if_addr, wdata: '0, be: '1};
            end
          end
        end
        ISSUE: begin
          if (bus.mem_ready) begin
            r_mem_req <= 1'b0;
            r_wd      <= '0;
            r_state   <= WAIT_RESP;
          end
        end
        WAIT_RESP: begin
          // A response arriving in the timeout cycle takes precedence over the error.
          if (bus.mem_rvalid) begin
            r_state <= IDLE;
            if (r_owner == OWN_D) begin
              r_d_rvalid <= 1'b1;
              r_d_rdata  <= w_resp;
            end else begin
              r_if_rvalid <= 1'b1;
              r_if_rdata  <= w_resp;
            end
          end else if (r_wd == WD_LAST) begin
            r_state <= IDLE;
            r_err   <= 1'b1;
            if (r_owner == OWN_D) begin
              r_d_rvalid <= 1'b1;
              r_d_rdata  <= '0;
            end else begin
              r_if_rvalid <= 1'b1;
              r_if_rdata  <= '0;
            end
          end else begin
            r_wd <= r_wd + WDW'(1);
          end
        end
        default: begin
          r_state   <= IDLE;
          r_mem_req <= 1'b0;
        end
      endcase
    end
  end

  assign bus.if_gnt    = w_accept && (r_owner == OWN_IF);
  assign bus.d_gnt     = w_accept && (r_owner == OWN_D);
  assign bus.if_rvalid = r_if_rvalid;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.d_rvalid  = r_d_rvalid;
  assign bus.d_rdata   = r_d_rdata;
  assign bus.err       = r_err;

  assign bus.mem_req   = r_mem_req;
  assign bus.mem_we    = r_cmd.we;
  assign bus.mem_addr  = r_cmd.addr;
  assign bus.mem_wdata = r_cmd.wdata;
  assign bus.mem_be    = r_cmd.be;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, store, arbitration, stall, timeout, stray response, reset.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(.MAX_WAIT(15)) dut (
    .i_clk   (clk),
    .i_reset (reset),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    bus.if_req = 0; bus.if_addr = '0;
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_be = '0;
    bus.mem_ready = 0; bus.mem_rvalid = 0; bus.mem_rdata = '0;

    // Reset state
    nxt(); nxt();
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_be", bus.mem_be, 0);
    chk("rst_if_rvalid", bus.if_rvalid, 0);
    chk("rst_d_rvalid", bus.d_rvalid, 0);
    chk("rst_err", bus.err, 0);
    reset = 0;

    // Single fetch, minimum latency
    bus.if_req = 1; bus.if_addr = 32'h0; bus.mem_ready = 1;
    #1 chk("f_gnt_n", bus.if_gnt, 0);
    nxt();
    chk("f_mem_req", bus.mem_req, 1);
    chk("f_mem_we", bus.mem_we, 0);
    chk("f_mem_addr", bus.mem_addr, 32'h0);
    chk("f_if_gnt", bus.if_gnt, 1);
    chk("f_d_gnt", bus.d_gnt, 0);
    bus.if_req = 0;
    nxt();
    chk("f_gnt_pulse", bus.if_gnt, 0);
    chk("f_mem_req_drop", bus.mem_req, 0);
    bus.mem_rvalid = 1; bus.mem_rdata = 32'h00500113;
    nxt();
    bus.mem_rvalid = 0;
    chk("f_if_rvalid", bus.if_rvalid, 1);
    chk("f_if_rdata", bus.if_rdata, 32'h00500113);
    chk("f_d_rvalid", bus.d_rvalid, 0);
    chk("f_err", bus.err, 0);
    nxt();
    chk("f_rvalid_pulse", bus.if_rvalid, 0);

    // Both requesting for four rounds
    bus.if_req = 1; bus.if_addr = 32'h200;
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h100; bus.d_be = 4'hF;
    for (int r = 0; r < 4; r++) begin
      logic exp_d;
`ifdef MEM_ARB_RR_EN
      exp_d = (r % 2 == 0);
`else
      exp_d = 1'b1;
`endif
      nxt();
      chk("arb_d_gnt", bus.d_gnt, exp_d);
      chk("arb_if_gnt", bus.if_gnt, !exp_d);
      chk("arb_addr", bus.mem_addr, exp_d ? 32'h100 : 32'h200);
      if (r == 3) begin
        bus.if_req = 0; bus.d_req = 0;
      end
      nxt();
      bus.mem_rvalid = 1; bus.mem_rdata = 32'hA0 + r;
      nxt();
      bus.mem_rvalid = 0;
      chk("arb_d_rvalid", bus.d_rvalid, exp_d);
      chk("arb_if_rvalid", bus.if_rvalid, !exp_d);
      chk("arb_rdata", exp_d ? bus.d_rdata : bus.if_rdata, 32'hA0 + r);
    end
    nxt();

    // Store: data forwarded, ack carries zero data
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'd44; bus.d_wdata = 32'hFFFFFFFD; bus.d_be = 4'hF;
    nxt();
    chk("st_mem_req", bus.mem_req, 1);
    chk("st_mem_we", bus.mem_we, 1);
    chk("st_mem_addr", bus.mem_addr, 32'd44);
    chk("st_mem_wdata", bus.mem_wdata, 32'hFFFFFFFD);
    chk("st_mem_be", bus.mem_be, 32'hF);
    chk("st_d_gnt", bus.d_gnt, 1);
    bus.d_req = 0; bus.d_we = 0;
    nxt();
    bus.mem_rvalid = 1; bus.mem_rdata = 32'hDEADBEEF;
    nxt();
    bus.mem_rvalid = 0;
    chk("st_d_rvalid", bus.d_rvalid, 1);
    chk("st_d_rdata", bus.d_rdata, 0);
    chk("st_err", bus.err, 0);

    // mem_ready held low five cycles, with a stray response while stalled
    bus.mem_ready = 0;
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h80;
    nxt();
    for (int i = 0; i < 5; i++) begin
      chk("stall_mem_req", bus.mem_req, 1);
      chk("stall_mem_addr", bus.mem_addr, 32'h80);
      chk("stall_d_gnt", bus.d_gnt, 0);
      chk("stall_d_rvalid", bus.d_rvalid, 0);
      bus.mem_rvalid = (i == 2);
      nxt();
    end
    bus.mem_rvalid = 0;
    bus.mem_ready = 1;
    #1 chk("stall_gnt", bus.d_gnt, 1);
    bus.d_req = 0;
    nxt();
    chk("stall_req_drop", bus.mem_req, 0);
    bus.mem_rvalid = 1; bus.mem_rdata = 32'h1234;
    nxt();
    bus.mem_rvalid = 0;
    chk("stall_d_rvalid_end", bus.d_rvalid, 1);
    chk("stall_d_rdata", bus.d_rdata, 32'h1234);

    // Timeout on a fetch, then a late response is ignored
    bus.if_req = 1; bus.if_addr = 32'h40;
    nxt();
    chk("to_if_gnt", bus.if_gnt, 1);
    bus.if_req = 0;
    for (int i = 1; i <= 15; i++) begin
      nxt();
      chk("to_wait_rvalid", bus.if_rvalid, 0);
      chk("to_wait_err", bus.err, 0);
    end
    nxt();
    chk("to_if_rvalid", bus.if_rvalid, 1);
    chk("to_err", bus.err, 1);
    chk("to_if_rdata", bus.if_rdata, 0);
    bus.mem_rvalid = 1; bus.mem_rdata = 32'h77;
    nxt();
    bus.mem_rvalid = 0;
    chk("late_if_rvalid", bus.if_rvalid, 0);
    chk("late_d_rvalid", bus.d_rvalid, 0);
    chk("late_err", bus.err, 0);
    chk("late_mem_req", bus.mem_req, 0);

    // Response in the timeout cycle wins over the error
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h90;
    nxt();
    chk("rw_d_gnt", bus.d_gnt, 1);
    bus.d_req = 0;
    for (int i = 1; i <= 15; i++) nxt();
    bus.mem_rvalid = 1; bus.mem_rdata = 32'h5A5A;
    nxt();
    bus.mem_rvalid = 0;
    chk("rw_d_rvalid", bus.d_rvalid, 1);
    chk("rw_err", bus.err, 0);
    chk("rw_d_rdata", bus.d_rdata, 32'h5A5A);

    // Reset during WAIT_RESP drops the access
    bus.d_req = 1; bus.d_addr = 32'h10;
    nxt();
    bus.d_req = 0;
    nxt();
    nxt();
    reset = 1;
    nxt();
    chk("rr_mem_req", bus.mem_req, 0);
    chk("rr_d_rvalid", bus.d_rvalid, 0);
    chk("rr_err", bus.err, 0);
    chk("rr_d_rdata", bus.d_rdata, 0);
    chk("rr_mem_addr", bus.mem_addr, 0);
    reset = 0;
    bus.mem_rvalid = 1; bus.mem_rdata = 32'h55;
    nxt();
    bus.mem_rvalid = 0;
    chk("rr_after_d_rvalid", bus.d_rvalid, 0);
    chk("rr_after_if_rvalid", bus.if_rvalid, 0);
    chk("rr_after_err", bus.err, 0);

    // Reset during ISSUE with mem_ready high: no grant
    bus.d_req = 1; bus.d_addr = 32'h20;
    nxt();
    chk("ri_mem_req", bus.mem_req, 1);
    reset = 1;
    #1 chk("ri_d_gnt", bus.d_gnt, 0);
    bus.d_req = 0;
    nxt();
    reset = 0;
    chk("ri_mem_req_drop", bus.mem_req, 0);
    nxt();
    chk("ri_idle", bus.mem_req, 0);
    chk("ri_d_rvalid", bus.d_rvalid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
